// File: rtl/backend_cmd_responder_if.sv
// Command / returned-data bundle between the scheduler (master) and the
// backend responder (slave).
//
// Handshake: a command transfers on a rising edge where
// i_frontend_command_valid && o_backend_controller_ready; a returned word
// transfers on a rising edge where o_returned_data_valid &&
// i_frontend_receive_ready. Neither ready may depend combinationally on its
// own valid, and a blocked return holds its data and id stable.
interface backend_cmd_responder_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6,
  parameter int ID_W   = 4
);
  logic              o_backend_controller_ready;
  logic              i_frontend_command_valid;
  logic              i_cmd_op;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [ID_W-1:0]   i_cmd_id;
  logic [DATA_W-1:0] i_frontend_write_data;
  logic              i_stall_backend_controller;
  logic              i_frontend_receive_ready;
  logic              o_returned_data_valid;
  logic [DATA_W-1:0] o_returned_data;
  logic [ID_W-1:0]   o_returned_id;

  modport slave (
    output o_backend_controller_ready,
    input  i_frontend_command_valid,
    input  i_cmd_op,
    input  i_cmd_addr,
    input  i_cmd_id,
    input  i_frontend_write_data,
    input  i_stall_backend_controller,
    input  i_frontend_receive_ready,
    output o_returned_data_valid,
    output o_returned_data,
    output o_returned_id
  );

  modport master (
    input  o_backend_controller_ready,
    output i_frontend_command_valid,
    output i_cmd_op,
    output i_cmd_addr,
    output i_cmd_id,
    output i_frontend_write_data,
    output i_stall_backend_controller,
    output i_frontend_receive_ready,
    input  o_returned_data_valid,
    input  o_returned_data,
    input  o_returned_id
  );
endinterface

// File: rtl/backend_cmd_responder.sv
// Backend stand-in: word memory written by frontend commands, reads returned
// in order through a fixed-latency delay line and a small return FIFO.
module backend_cmd_responder #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 6,
  parameter int ID_W       = 4,
  parameter int READ_LAT   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  backend_cmd_responder_if.slave bus
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCNT_W    = $clog2(FIFO_DEPTH) + 1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ID_W-1:0]   id_t;

  word_t               mem_q       [MEM_DEPTH];
  word_t               mem_d       [MEM_DEPTH];
  logic [READ_LAT-1:0] dl_vld_q, dl_vld_d;
  word_t               dl_data_q   [READ_LAT];
  word_t               dl_data_d   [READ_LAT];
  id_t                 dl_id_q     [READ_LAT];
  id_t                 dl_id_d     [READ_LAT];
  word_t               fifo_data_q [FIFO_DEPTH];
  word_t               fifo_data_d [FIFO_DEPTH];
  id_t                 fifo_id_q   [FIFO_DEPTH];
  id_t                 fifo_id_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [OCNT_W-1:0]   outstanding_q, outstanding_d;

  logic ready;
  logic accept;
  logic wr_acc;
  logic rd_acc;
  logic push;
  logic pop;

  // Outstanding counts both the delay line and the FIFO, so a full count
  // guarantees the FIFO can absorb everything still in flight.
  assign ready  = !i_rst && !bus.i_stall_backend_controller &&
                  (outstanding_q < OCNT_W'(FIFO_DEPTH));
  assign accept = bus.i_frontend_command_valid && ready;
  assign wr_acc = accept && bus.i_cmd_op;
  assign rd_acc = accept && !bus.i_cmd_op;
  assign push   = dl_vld_q[READ_LAT-1];
  assign pop    = (fifo_cnt_q != '0) && bus.i_frontend_receive_ready;

  assign bus.o_backend_controller_ready = ready;
  assign bus.o_returned_data_valid      = (fifo_cnt_q != '0);
  assign bus.o_returned_data            = fifo_data_q[rd_ptr_q];
  assign bus.o_returned_id              = fifo_id_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[bus.i_cmd_addr] = bus.i_frontend_write_data;
    end
  end

  // The delay line shifts every cycle regardless of stall or backpressure.
  always_comb begin
    dl_vld_d     = '0;
    dl_data_d    = dl_data_q;
    dl_id_d      = dl_id_q;
    dl_vld_d[0]  = rd_acc;
    dl_data_d[0] = rd_acc ? mem_q[bus.i_cmd_addr] : '0;
    dl_id_d[0]   = rd_acc ? bus.i_cmd_id : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_data_d[i] = dl_data_q[i-1];
      dl_id_d[i]   = dl_id_q[i-1];
    end
  end

  always_comb begin
    fifo_data_d   = fifo_data_q;
    fifo_id_d     = fifo_id_q;
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d    = fifo_cnt_q + OCNT_W'(push) - OCNT_W'(pop);
    outstanding_d = outstanding_q + OCNT_W'(rd_acc) - OCNT_W'(pop);
    if (push) begin
      fifo_data_d[wr_ptr_q] = dl_data_q[READ_LAT-1];
      fifo_id_d[wr_ptr_q]   = dl_id_q[READ_LAT-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dl_vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        dl_data_q[i] <= '0;
        dl_id_q[i]   <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      mem_q         <= mem_d;
      dl_vld_q      <= dl_vld_d;
      dl_data_q     <= dl_data_d;
      dl_id_q       <= dl_id_d;
      fifo_data_q   <= fifo_data_d;
      fifo_id_q     <= fifo_id_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_backend_cmd_responder.sv
// Directed bench for backend_cmd_responder: reset, write/read latency,
// backpressure ordering, stall and mid-operation reset.
module tb_backend_cmd_responder;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 6;
  localparam int ID_W       = 4;
  localparam int READ_LAT   = 4;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pat_a5;
  logic [DATA_W-1:0] exp_d;

  backend_cmd_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  backend_cmd_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard compare
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_frontend_command_valid = 1'b0;
    bus.i_cmd_op                 = 1'b0;
    bus.i_cmd_addr               = '0;
    bus.i_cmd_id                 = '0;
    bus.i_frontend_write_data    = '0;
  endtask

  task automatic drive_cmd(input logic op, input logic [ADDR_W-1:0] a,
                           input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    bus.i_frontend_command_valid = 1'b1;
    bus.i_cmd_op                 = op;
    bus.i_cmd_addr               = a;
    bus.i_cmd_id                 = id;
    bus.i_frontend_write_data    = d;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drive_cmd(1'b1, a, '0, d);
    step();
    drive_idle();
  endtask

  // Single read into an empty pipe with receive_ready high.
  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    drive_cmd(1'b0, a, id, '0);
    #1;
    check({tag, "_rdy"}, bus.o_backend_controller_ready, 1);
    step();
    drive_idle();
    check({tag, "_vld_n0"}, bus.o_returned_data_valid, 0);
    for (int k = 1; k < READ_LAT; k++) begin
      step();
      check({tag, "_vld_early"}, bus.o_returned_data_valid, 0);
    end
    step();
    check({tag, "_vld"}, bus.o_returned_data_valid, 1);
    check({tag, "_data"}, bus.o_returned_data, d);
    check({tag, "_id"}, bus.o_returned_id, DATA_W'(id));
    step();
    check({tag, "_vld_after_pop"}, bus.o_returned_data_valid, 0);
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    bus.i_stall_backend_controller = 1'b0;
    bus.i_frontend_receive_ready   = 1'b1;
    drive_idle();

    // 1. reset asserted mid-cycle, then released with stall low
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("rst_vld", bus.o_returned_data_valid, 0);
    check("rst_data", bus.o_returned_data, 0);
    check("rst_id", bus.o_returned_id, 0);
    check("rst_rdy", bus.o_backend_controller_ready, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rel_rdy", bus.o_backend_controller_ready, 1);
    check("rel_vld", bus.o_returned_data_valid, 0);

    // 2. write then read back
    write_word(6'd5, pat_a5);
    read_expect("wr_rd", 6'd5, 4'd3, pat_a5);

    // 3. unwritten address reads zero
    read_expect("unwr", 6'd7, 4'd1, '0);

    // 4. backpressure: fill to FIFO_DEPTH, then drain in order
    for (int i = 0; i < 5; i++) begin
      write_word(ADDR_W'(16 + i), {4{32'hC0DE_0000 + 32'(i)}});
    end
    bus.i_frontend_receive_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, ADDR_W'(16 + i), ID_W'(i), '0);
      #1;
      check("bp_rdy_fill", bus.o_backend_controller_ready, 1);
      exp_q.push_back({4{32'hC0DE_0000 + 32'(i)}});
      step();
    end
    drive_cmd(1'b0, 6'd20, 4'd4, '0);
    #1;
    check("bp_rdy_full", bus.o_backend_controller_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_hold_rdy", bus.o_backend_controller_ready, 0);
      check("bp_hold_vld", bus.o_returned_data_valid, 1);
      check("bp_hold_id", bus.o_returned_id, 0);
      check("bp_hold_data", bus.o_returned_data, exp_q[0]);
    end
    bus.i_frontend_receive_ready = 1'b1;
    #1;
    check("bp_no_passthru", bus.o_backend_controller_ready, 0);
    for (int k = 0; k < 4; k++) begin
      exp_d = exp_q.pop_front();
      check("bp_drain_vld", bus.o_returned_data_valid, 1);
      check("bp_drain_id", bus.o_returned_id, DATA_W'(k));
      check("bp_drain_data", bus.o_returned_data, exp_d);
      step();
      if (k == 0) check("bp_rdy_after_pop", bus.o_backend_controller_ready, 1);
      if (k == 1) drive_idle();
    end
    check("bp_id4_gap0", bus.o_returned_data_valid, 0);
    step();
    check("bp_id4_gap1", bus.o_returned_data_valid, 0);
    step();
    check("bp_id4_vld", bus.o_returned_data_valid, 1);
    check("bp_id4_id", bus.o_returned_id, 4);
    check("bp_id4_data", bus.o_returned_data, {4{32'hC0DE_0004}});
    step();
    check("bp_empty", bus.o_returned_data_valid, 0);

    // 5. stall blocks acceptance but not in-flight returns
    drive_cmd(1'b0, 6'd5, 4'd2, '0);
    #1;
    check("st_rdy_pre", bus.o_backend_controller_ready, 1);
    step();
    bus.i_stall_backend_controller = 1'b1;
    drive_cmd(1'b0, 6'd7, 4'd9, '0);
    #1;
    check("st_rdy0", bus.o_backend_controller_ready, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("st_rdy", bus.o_backend_controller_ready, 0);
      check("st_vld", bus.o_returned_data_valid, DATA_W'(k == READ_LAT));
      if (k == READ_LAT) begin
        check("st_id", bus.o_returned_id, 2);
        check("st_data", bus.o_returned_data, pat_a5);
      end
    end
    bus.i_stall_backend_controller = 1'b0;
    drive_idle();
    #1;
    check("st_rdy_post", bus.o_backend_controller_ready, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("st_no_extra", bus.o_returned_data_valid, 0);
    end

    // 6. reset with reads in flight
    write_word(6'd9, 128'd1);
    drive_cmd(1'b0, 6'd9, 4'd0, '0);
    step();
    drive_cmd(1'b0, 6'd9, 4'd1, '0);
    step();
    drive_idle();
    step();
    rst = 1'b1;
    #1;
    check("mr_rst_vld", bus.o_returned_data_valid, 0);
    check("mr_rst_rdy", bus.o_backend_controller_ready, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("mr_no_ret", bus.o_returned_data_valid, 0);
    end
    read_expect("mr_rd9", 6'd9, 4'd5, '0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
